addsub_seq: RTL and testbench
=============================

ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter SLICE, default 4, meaning bits processed per clock cycle.
REQ-003 WIDTH SHALL be a multiple of SLICE; NSL = WIDTH/SLICE SHALL be at least 1.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock, rising edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit, meaning the synchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit, meaning the operation request.
REQ-007 The block SHALL have port mode, input, 1 bit, meaning 0 = a+b and 1 = a-b (a + ~b + 1).
REQ-008 The block SHALL have ports a and b, input, WIDTH bits each, meaning the operands.
REQ-009 The block SHALL have port busy, output, 1 bit, meaning an operation is in progress (RUN or DONE).
REQ-010 The block SHALL have port done, output, 1 bit, meaning a one-cycle result-valid pulse.
REQ-011 The block SHALL have port result, output, WIDTH bits, meaning the sum or difference.
REQ-012 The block SHALL have port c_out, output, 1 bit, meaning carry out of the MSB; for subtract, 1 = no borrow.
REQ-013 The block SHALL have port ovf, output, 1 bit, meaning two's-complement signed overflow.
REQ-014 The block SHALL have port zero, output, 1 bit, meaning result == 0.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 IDLE: start=1 at a rising edge SHALL latch a, b and mode, set carry = mode, set slice index to 0, and move to RUN.
REQ-017 RUN: each edge SHALL process one slice, LSB slice first, with result[idx*SLICE +: SLICE] = a_slice + (b_slice XOR {SLICE{mode}}) + carry.
REQ-018 RUN: the carry out of each slice SHALL become the carry-in of the next slice.
REQ-019 RUN: after slice NSL-1 is processed, the FSM SHALL move to DONE; RUN SHALL last exactly NSL cycles.
REQ-020 DONE: done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-021 Latency: with start sampled at edge k, done SHALL be high in the cycle following edge k+NSL.
REQ-022 c_out, ovf and zero SHALL be valid whenever done=1.
REQ-023 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-024 result and all flags SHALL hold their values after DONE until the next accepted start.
REQ-025 On an accepted start, result, c_out, ovf and zero SHALL keep their previous values until they are overwritten slice by slice.
REQ-026 start in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-027 Operand changes on a or b after acceptance SHALL have no effect on the current operation.
REQ-028 The earliest back-to-back start SHALL be accepted in the first IDLE cycle after DONE, giving a throughput of one operation per NSL+2 cycles.
REQ-029 busy SHALL be 1 in RUN and DONE and 0 in IDLE.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force IDLE and clear busy, done, result, c_out, ovf, zero and the internal carry and index to 0.
REQ-031 Reset mid-operation (RUN or DONE) SHALL abort the operation with no done pulse.
REQ-032 A start asserted in the same cycle as rst_n=0 SHALL be ignored.
REQ-033 The first start SHALL be accepted at the first edge where rst_n=1.

Verification (WIDTH=16, SLICE=4)
REQ-034 Add: a=0x1234, b=0x0FFF, mode=0 -> done 5 cycles after the start edge; result=0x2233, c_out=0, ovf=0, zero=0.
REQ-035 Signed overflow: a=0x7FFF, b=0x0001, mode=0 -> result=0x8000, c_out=0, ovf=1.
REQ-036 Wrap to zero: a=0xFFFF, b=0x0001, mode=0 -> result=0x0000, c_out=1, ovf=0, zero=1.
REQ-037 Subtract with borrow: a=0x0005, b=0x0007, mode=1 -> result=0xFFFE, c_out=0, ovf=0; then a=0x8000, b=0x0001, mode=1 -> result=0x7FFF, c_out=1, ovf=1.
REQ-038 Ignored start: start pulsed during RUN with different operands -> exactly one done pulse, carrying the first operation's result; busy stays 1 for 5 cycles.
REQ-039 Reset mid-operation: rst_n=0 after 2 RUN cycles -> next cycle busy=0, result=0x0000, and no done pulse; a subsequent 0x0001+0x0001 -> result=0x0002.

Source files
------------

// File: rtl/addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : addsub_seq
// Purpose  : Multi-cycle adder/subtractor. It processes SLICE bits per clock,
//            starting with the LSB slice. The carry passes from slice to slice
//            through a register.
//            mode=0 computes a+b. mode=1 computes a-b as a + ~b + 1.
// Ports    : clk     - clock, rising edge active
//            rst_n   - synchronous active-low reset
//            start   - operation request, accepted only in IDLE
//            mode    - 0 = add, 1 = subtract
//            a, b    - WIDTH-bit operands, latched when start is accepted
//            busy    - high in RUN and DONE
//            done    - one-cycle result-valid pulse
//            result  - WIDTH-bit sum or difference
//            c_out   - carry out of the MSB (subtract: 1 = no borrow)
//            ovf     - two's-complement signed overflow
//            zero    - result == 0
// Revision : 1.0 - initial release
// ============================================================================
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int                 c_NSL      = WIDTH / SLICE;
  localparam int                 c_IDX_W    = (c_NSL > 1) ? $clog2(c_NSL) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NSL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q,  state_d;
  logic [WIDTH-1:0]   a_q,      a_d;
  logic [WIDTH-1:0]   b_q,      b_d;
  logic               mode_q,   mode_d;
  logic               carry_q,  carry_d;
  logic [c_IDX_W-1:0] idx_q,    idx_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               c_out_q,  c_out_d;
  logic               ovf_q,    ovf_d;
  logic               zero_q,   zero_d;

  // Datapath for the slice selected by idx_q
  logic [SLICE-1:0]   a_sl;
  logic [SLICE-1:0]   b_sl;
  logic [SLICE:0]     slice_sum;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    a_sl      = a_q[int'(idx_q)*SLICE +: SLICE];
    // Subtraction inverts b here. The +1 is the carry seeded with mode at start.
    b_sl      = b_q[int'(idx_q)*SLICE +: SLICE] ^ {SLICE{mode_q}};
    slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(carry_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          carry_d = mode;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        result_d[int'(idx_q)*SLICE +: SLICE] = slice_sum[SLICE-1:0];
        carry_d = slice_sum[SLICE];
        if (idx_q == c_LAST_IDX) begin
          state_d = DONE;
          c_out_d = slice_sum[SLICE];
          // Overflow occurs when both effective operands have the same sign
          // and the sum has the other sign. This equals
          // carry-in(MSB) XOR carry-out(MSB).
          ovf_d   = (a_sl[SLICE-1] == b_sl[SLICE-1]) &&
                    (slice_sum[SLICE-1] != a_sl[SLICE-1]);
          zero_d  = (result_d == '0);
        end else begin
          idx_d = idx_q + c_IDX_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign c_out  = c_out_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_seq
// Purpose  : Self-checking bench for addsub_seq (WIDTH=16, SLICE=4).
//            Expected values come from an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_seq;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int NSL   = WIDTH / SLICE;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             mode  = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             ovf;
  logic             zero;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .ovf    (ovf),
    .zero   (zero)
  );

  // Reference model: signed and unsigned integer arithmetic.
  // Returns {ovf, c_out, result}.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic m);
    longint           ux, uy, sx, sy, s;
    longint           smax, smin;
    logic [WIDTH-1:0] r;
    logic             co, ov;
    ux   = longint'(x);
    uy   = longint'(y);
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    smax = (longint'(1) << (WIDTH-1)) - 1;
    smin = -(longint'(1) << (WIDTH-1));
    if (!m) begin
      r  = x + y;
      co = (ux + uy) >= (longint'(1) << WIDTH);
      s  = sx + sy;
    end else begin
      r  = x - y;
      co = (ux >= uy);
      s  = sx - sy;
    end
    ov = (s > smax) || (s < smin);
    return {ov, co, r};
  endfunction

  // Stimulus driver. It issues one operation, then scrambles the operand
  // inputs. Optionally it pulses start again at cycle poke_at. It observes
  // done, busy and the outputs for a bounded window.
  task automatic do_op(input  logic [WIDTH-1:0] xa,
                       input  logic [WIDTH-1:0] xb,
                       input  logic             xm,
                       input  int               poke_at,
                       output int               lat,
                       output int               done_cnt,
                       output int               busy_cnt,
                       output logic [WIDTH-1:0] res_done,
                       output logic             co_done,
                       output logic             ov_done,
                       output logic             z_done,
                       output logic [WIDTH-1:0] res_after_start);
    @(negedge clk);
    a = xa; b = xb; mode = xm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    res_after_start = result;
    a    = WIDTH'($urandom);
    b    = WIDTH'($urandom);
    mode = 1'($urandom);
    lat = -1; done_cnt = 0; busy_cnt = 0;
    res_done = '0; co_done = 1'b0; ov_done = 1'b0; z_done = 1'b0;
    for (int i = 0; i < NSL + 6; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = i; res_done = result; co_done = c_out; ov_done = ovf; z_done = zero;
        end
      end
      if (i == poke_at) begin
        start = 1'b1; a = ~xa; b = xb + 16'h1; mode = ~xm;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    // Assert start while reset is low. It must be ignored.
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; a = 16'h0003; b = 16'h0004; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++;
    if ({result, c_out, ovf, zero} !== '0)
      begin miscompares++; $display("FAIL reset_outputs: got %h/%b%b%b expected 0", result, c_out, ovf, zero); end
    // The first edge with rst_n=1 must accept start.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL first_start_accept: busy got %b expected 1", busy); end
    repeat (NSL + 3) @(posedge clk);
    #1;
    vectors++;
    if (result !== 16'h0007) begin miscompares++; $display("FAIL first_start_result: got %h expected 0007", result); end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] ta [5] = '{16'h1234, 16'h7FFF, 16'hFFFF, 16'h0005, 16'h8000};
    logic [WIDTH-1:0] tb [5] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic             tm [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [WIDTH-1:0] er [5] = '{16'h2233, 16'h8000, 16'h0000, 16'hFFFE, 16'h7FFF};
    logic             ec [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic             eo [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int lat, dc, bc;
    logic [WIDTH-1:0] r, r0;
    logic co, ov, z;
    for (int k = 0; k < 5; k++) begin
      do_op(ta[k], tb[k], tm[k], -1, lat, dc, bc, r, co, ov, z, r0);
      // done is high in the 5th cycle after the start edge, NSL edges later.
      vectors++;
      if (lat !== NSL) begin miscompares++; $display("FAIL dir%0d_latency: got %0d expected %0d", k, lat, NSL); end
      vectors++;
      if (dc !== 1) begin miscompares++; $display("FAIL dir%0d_done_count: got %0d expected 1", k, dc); end
      vectors++;
      if (r !== er[k]) begin miscompares++; $display("FAIL dir%0d_result: got %h expected %h", k, r, er[k]); end
      vectors++;
      if (co !== ec[k]) begin miscompares++; $display("FAIL dir%0d_c_out: got %b expected %b", k, co, ec[k]); end
      vectors++;
      if (ov !== eo[k]) begin miscompares++; $display("FAIL dir%0d_ovf: got %b expected %b", k, ov, eo[k]); end
      vectors++;
      if (z !== (er[k] == '0)) begin miscompares++; $display("FAIL dir%0d_zero: got %b expected %b", k, z, (er[k] == '0)); end
      vectors++;
      if (result !== er[k]) begin miscompares++; $display("FAIL dir%0d_hold: got %h expected %h", k, result, er[k]); end
    end
  endtask

  task automatic test_random();
    int lat, dc, bc;
    logic [WIDTH-1:0] xa, xb, r, r0, prev;
    logic xm, co, ov, z;
    logic [WIDTH+1:0] exp_v;
    prev = 16'h7FFF;  // result left by the last directed operation
    for (int k = 0; k < 30; k++) begin
      xa = WIDTH'($urandom);
      xb = (k % 7 == 0) ? xa : WIDTH'($urandom);  // a=b sometimes, to hit zero
      xm = 1'($urandom);
      exp_v = model(xa, xb, xm);
      do_op(xa, xb, xm, -1, lat, dc, bc, r, co, ov, z, r0);
      vectors++;
      if (r0 !== prev) begin miscompares++; $display("FAIL rnd%0d_keep_prev: got %h expected %h", k, r0, prev); end
      vectors++;
      if (lat !== NSL || dc !== 1 || bc !== NSL + 1)
        begin miscompares++; $display("FAIL rnd%0d_timing: lat %0d done %0d busy %0d expected %0d 1 %0d", k, lat, dc, bc, NSL, NSL + 1); end
      vectors++;
      if ({ov, co, r, z} !== {exp_v, exp_v[WIDTH-1:0] == '0})
        begin miscompares++; $display("FAIL rnd%0d_value: %h %s %h got r=%h c=%b v=%b z=%b expected r=%h c=%b v=%b", k, xa, xm ? "-" : "+", xb, r, co, ov, z, exp_v[WIDTH-1:0], exp_v[WIDTH], exp_v[WIDTH+1]); end
      prev = exp_v[WIDTH-1:0];
    end
  endtask

  task automatic test_ignored_start();
    int lat, dc, bc;
    logic [WIDTH-1:0] r, r0;
    logic co, ov, z;
    int pokes [2] = '{1, NSL};  // start during RUN, then during DONE
    for (int k = 0; k < 2; k++) begin
      do_op(16'h1111, 16'h2222, 1'b0, pokes[k], lat, dc, bc, r, co, ov, z, r0);
      vectors++;
      if (dc !== 1) begin miscompares++; $display("FAIL ign%0d_done_count: got %0d expected 1", k, dc); end
      vectors++;
      if (bc !== NSL + 1) begin miscompares++; $display("FAIL ign%0d_busy_cycles: got %0d expected %0d", k, bc, NSL + 1); end
      vectors++;
      if (r !== 16'h3333) begin miscompares++; $display("FAIL ign%0d_result: got %h expected 3333", k, r); end
    end
  endtask

  task automatic test_back_to_back();
    int dones [$];
    @(negedge clk);
    a = 16'h0100; b = 16'h0023; mode = 1'b0; start = 1'b1;
    for (int c = 0; c < 3 * (NSL + 2) + 2; c++) begin
      @(posedge clk); #1;
      if (done) dones.push_back(c);
    end
    start = 1'b0;
    repeat (NSL + 4) @(posedge clk);
    #1;
    vectors++;
    if (dones.size() !== 3) begin miscompares++; $display("FAIL b2b_done_count: got %0d expected 3", dones.size()); end
    for (int k = 1; k < dones.size(); k++) begin
      vectors++;
      if (dones[k] - dones[k-1] !== NSL + 2)
        begin miscompares++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", k, dones[k] - dones[k-1], NSL + 2); end
    end
    vectors++;
    if (result !== 16'h0123) begin miscompares++; $display("FAIL b2b_result: got %h expected 0123", result); end
  endtask

  task automatic test_reset_mid();
    int lat, dc, bc, seen;
    logic [WIDTH-1:0] r, r0;
    logic co, ov, z;
    @(negedge clk);
    a = 16'hABCD; b = 16'h1357; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);  // two RUN cycles
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    vectors++;
    if (result !== 16'h0000) begin miscompares++; $display("FAIL rstmid_result: got %h expected 0000", result); end
    seen = 0;
    for (int c = 0; c < NSL + 4; c++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", seen); end
    do_op(16'h0001, 16'h0001, 1'b0, -1, lat, dc, bc, r, co, ov, z, r0);
    vectors++;
    if (r !== 16'h0002 || dc !== 1) begin miscompares++; $display("FAIL rstmid_after: got %h (%0d done) expected 0002 (1 done)", r, dc); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
